// File: rtl/mem_if_pkg.sv
// -----------------------------------------------------------------------------
// mem_if_pkg
// Shared types and helpers for the load/store initiator and its lane aligner.
//   size_e      : access size encoding carried on req_size
//   cause_e     : completion cause reported on done_cause
//   lsu_state_e : initiator FSM states
//   size_mask() : byte-enable pattern of an access before lane shifting
// -----------------------------------------------------------------------------
package mem_if_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_BUS     = 2'd1,
        CAUSE_TIMEOUT = 2'd2,
        CAUSE_ILLEGAL = 2'd3
    } cause_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2,
        S_DONE  = 2'd3
    } lsu_state_e;

    // Byte enables of an access sitting at offset 0; illegal size enables nothing.
    function automatic logic [WORD_BYTES-1:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_mask = 4'h1;
            SZ_HALF: size_mask = 4'h3;
            SZ_WORD: size_mask = 4'hF;
            default: size_mask = 4'h0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align
// Purely combinational lane logic for the load/store initiator.
//   size, off      : access size and byte offset inside the first word
//   uns            : zero-extend (1) or sign-extend (0) load data
//   wdata          : right-justified store data
//   rd_beat0/1     : read data of first / second word (second is 0 if unsplit)
//   mask8          : byte enables across the two-word window {beat1, beat0}
//   split          : access touches the second word
//   wdata_lo/hi    : lane-positioned store data for beat0 / beat1
//   rdata          : reassembled and extended load result
// -----------------------------------------------------------------------------
module lsu_lane_align
    import mem_if_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] rd_beat0,
    input  logic [31:0] rd_beat1,
    output logic [7:0]  mask8,
    output logic        split,
    output logic [31:0] wdata_lo,
    output logic [31:0] wdata_hi,
    output logic [31:0] rdata
);

    logic [63:0] wshift;
    logic [31:0] rshift;
    logic        ext;

    always_comb begin
        mask8 = {4'b0000, size_mask(size)} << off;
        split = (mask8[7:4] != 4'b0000);

        // Shifting through a 64-bit window gives both beats at once: the bytes
        // pushed past bit 31 are exactly the beat1 data, already lane-aligned.
        wshift   = {32'h0, wdata} << {off, 3'b000};
        wdata_lo = wshift[31:0];
        wdata_hi = wshift[63:32];

        rshift = 32'({rd_beat1, rd_beat0} >> {off, 3'b000});
        ext    = 1'b0;
        rdata  = 32'h0;
        case (size)
            SZ_BYTE: begin
                ext   = ~uns & rshift[7];
                rdata = {{24{ext}}, rshift[7:0]};
            end
            SZ_HALF: begin
                ext   = ~uns & rshift[15];
                rdata = {{16{ext}}, rshift[15:0]};
            end
            SZ_WORD: rdata = rshift;
            default: rdata = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// -----------------------------------------------------------------------------
// lsu_mem_initiator
// Turns one pipeline load/store into one or two single-word memory beats and
// returns a single completion pulse.
//   clk, rst_n            : clock, synchronous active-low reset
//   req_*                 : pipeline request (valid/ready handshake)
//   done_*                : one-cycle completion with load data and cause
//   r_v, w_v, adr, data,
//   strobe                : registered memory request
//   resp, resp_valid,
//   resp_error            : memory response
// -----------------------------------------------------------------------------
module lsu_mem_initiator
    import mem_if_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_adr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            done_valid,
    output logic [XLEN-1:0] done_rdata,
    output logic            done_error,
    output logic [1:0]      done_cause,
    output logic            r_v,
    output logic            w_v,
    output logic [XLEN-1:0] adr,
    output logic [XLEN-1:0] data,
    output logic [3:0]      strobe,
    input  logic [XLEN-1:0] resp,
    input  logic            resp_valid,
    input  logic            resp_error
);

    localparam int TW = $clog2(TIMEOUT + 1);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] wdata_q, wdata_d;
    logic        split_q, split_d;
    logic [31:0] rd0_q, rd0_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic        r_v_q, r_v_d, w_v_q, w_v_d;
    logic [31:0] adr_q, adr_d, data_q, data_d;
    logic [3:0]  strobe_q, strobe_d;
    logic        done_valid_q, done_valid_d, done_error_q, done_error_d;
    logic [31:0] done_rdata_q, done_rdata_d;
    logic [1:0]  done_cause_q, done_cause_d;

    logic        idle;
    logic [1:0]  al_size, al_off;
    logic [31:0] al_wdata, al_b0, al_b1;
    logic [7:0]  al_mask8;
    logic        al_split;
    logic [31:0] al_wlo, al_whi, al_rdata;

    logic        fin, next_beat1;
    cause_e      fin_cause;
    logic [31:0] fin_rdata;

    assign idle      = (state_q == S_IDLE);
    assign req_ready = rst_n && idle;

    // In IDLE the aligner looks at the incoming request so beat0 can be
    // registered on the accepting edge; afterwards it uses the latched copy.
    assign al_size  = idle ? req_size : size_q;
    assign al_off   = idle ? req_adr[1:0] : off_q;
    assign al_wdata = idle ? req_wdata : wdata_q;
    // The final read beat completes on the edge its response arrives, so the
    // live response word is fed straight into the reassembly.
    assign al_b0    = (state_q == S_BEAT0) ? resp : rd0_q;
    assign al_b1    = (state_q == S_BEAT1) ? resp : 32'h0;

    lsu_lane_align u_align (
        .size     (al_size),
        .off      (al_off),
        .uns      (uns_q),
        .wdata    (al_wdata),
        .rd_beat0 (al_b0),
        .rd_beat1 (al_b1),
        .mask8    (al_mask8),
        .split    (al_split),
        .wdata_lo (al_wlo),
        .wdata_hi (al_whi),
        .rdata    (al_rdata)
    );

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        split_d      = split_q;
        rd0_d        = rd0_q;
        tmo_d        = tmo_q;
        r_v_d        = 1'b0;
        w_v_d        = 1'b0;
        adr_d        = adr_q;
        data_d       = data_q;
        strobe_d     = strobe_q;
        done_valid_d = 1'b0;
        done_error_d = done_error_q;
        done_cause_d = done_cause_q;
        done_rdata_d = done_rdata_q;
        fin          = 1'b0;
        fin_cause    = CAUSE_NONE;
        fin_rdata    = 32'h0;
        next_beat1   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    off_d   = req_adr[1:0];
                    wdata_d = req_wdata;
                    split_d = al_split;
                    tmo_d   = '0;
                    if (req_size == SZ_ILL) begin
                        fin       = 1'b1;
                        fin_cause = CAUSE_ILLEGAL;
                    end else begin
                        state_d  = S_BEAT0;
                        adr_d    = {req_adr[31:2], 2'b00};
                        strobe_d = al_mask8[3:0];
                        data_d   = al_wlo;
                        r_v_d    = ~req_we;
                        w_v_d    = req_we;
                    end
                end
            end

            S_BEAT0, S_BEAT1: begin
                if (we_q) begin
                    // Write beats last one cycle; an error seen in that cycle ends the access.
                    if (resp_error) begin
                        fin       = 1'b1;
                        fin_cause = CAUSE_BUS;
                    end else if (state_q == S_BEAT0 && split_q) begin
                        next_beat1 = 1'b1;
                    end else begin
                        fin = 1'b1;
                    end
                end else begin
                    if (resp_error) begin
                        fin       = 1'b1;
                        fin_cause = CAUSE_BUS;
                    end else if (resp_valid) begin
                        if (state_q == S_BEAT0) begin
                            rd0_d = resp;
                        end
                        if (state_q == S_BEAT0 && split_q) begin
                            next_beat1 = 1'b1;
                        end else begin
                            fin       = 1'b1;
                            fin_rdata = al_rdata;
                        end
                    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                        fin       = 1'b1;
                        fin_cause = CAUSE_TIMEOUT;
                    end else begin
                        // Keep the read request up; adr and strobe hold by default.
                        r_v_d = 1'b1;
                        tmo_d = tmo_q + TW'(1);
                    end
                end

                if (next_beat1) begin
                    state_d  = S_BEAT1;
                    adr_d    = adr_q + 32'd4;
                    strobe_d = al_mask8[7:4];
                    data_d   = al_whi;
                    r_v_d    = ~we_q;
                    w_v_d    = we_q;
                    tmo_d    = '0;
                end
            end

            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (fin) begin
            state_d      = S_DONE;
            done_valid_d = 1'b1;
            done_error_d = (fin_cause != CAUSE_NONE);
            done_cause_d = fin_cause;
            done_rdata_d = fin_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            off_q        <= 2'b00;
            wdata_q      <= 32'h0;
            split_q      <= 1'b0;
            rd0_q        <= 32'h0;
            tmo_q        <= '0;
            r_v_q        <= 1'b0;
            w_v_q        <= 1'b0;
            adr_q        <= 32'h0;
            data_q       <= 32'h0;
            strobe_q     <= 4'h0;
            done_valid_q <= 1'b0;
            done_error_q <= 1'b0;
            done_rdata_q <= 32'h0;
            done_cause_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            wdata_q      <= wdata_d;
            split_q      <= split_d;
            rd0_q        <= rd0_d;
            tmo_q        <= tmo_d;
            r_v_q        <= r_v_d;
            w_v_q        <= w_v_d;
            adr_q        <= adr_d;
            data_q       <= data_d;
            strobe_q     <= strobe_d;
            done_valid_q <= done_valid_d;
            done_error_q <= done_error_d;
            done_rdata_q <= done_rdata_d;
            done_cause_q <= done_cause_d;
        end
    end

    assign r_v        = r_v_q;
    assign w_v        = w_v_q;
    assign adr        = adr_q;
    assign data       = data_q;
    assign strobe     = strobe_q;
    assign done_valid = done_valid_q;
    assign done_error = done_error_q;
    assign done_rdata = done_rdata_q;
    assign done_cause = done_cause_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_initiator
// Scoreboard bench: each request pushes its expected memory beats and its
// expected completion; a responder pops beats as the DUT issues them and a
// completion monitor pops results when done_valid fires.
// -----------------------------------------------------------------------------
module tb_lsu_mem_initiator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_adr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        done_valid;
    logic [31:0] done_rdata;
    logic        done_error;
    logic [1:0]  done_cause;
    logic        r_v, w_v;
    logic [31:0] adr, data;
    logic [3:0]  strobe;
    logic [31:0] resp = 32'h0;
    logic        resp_valid = 1'b0;
    logic        resp_error = 1'b0;

    always #5 clk = ~clk;

    lsu_mem_initiator #(.XLEN(32), .TIMEOUT(15)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_adr      (req_adr),
        .req_wdata    (req_wdata),
        .done_valid   (done_valid),
        .done_rdata   (done_rdata),
        .done_error   (done_error),
        .done_cause   (done_cause),
        .r_v          (r_v),
        .w_v          (w_v),
        .adr          (adr),
        .data         (data),
        .strobe       (strobe),
        .resp         (resp),
        .resp_valid   (resp_valid),
        .resp_error   (resp_error)
    );

    typedef struct {
        logic [31:0] adr;
        logic [3:0]  strobe;
        logic [31:0] data;
        bit          chk_data;
    } beat_t;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  cause;
        int          lat;
    } done_t;

    beat_t       beat_q[$];
    done_t       done_q[$];
    beat_t       bexp;
    done_t       dexp;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          rv_hi = 0;
    int          beat_idx = 0;
    int          err_beat = -1;
    bit          seen = 1'b0;
    bit          noresp = 1'b0;
    logic [31:0] rdat [2];
    string       cur_tag = "";

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: checks each new beat against the scoreboard and
    // answers reads immediately unless told to stay silent or to error.
    always @(negedge clk) begin
        resp_valid = 1'b0;
        resp_error = 1'b0;
        if (rst_n && (r_v || w_v) && !seen) begin
            check("rw_excl", {31'h0, r_v & w_v}, 32'h0);
            check("beat_present", 32'(beat_q.size() != 0), 32'h1);
            if (beat_q.size() != 0) begin
                bexp = beat_q.pop_front();
                check("beat_adr", adr, bexp.adr);
                check("beat_strobe", {28'h0, strobe}, {28'h0, bexp.strobe});
                if (bexp.chk_data) check("beat_data", data, bexp.data);
            end
            seen = 1'b1;
        end
        if (rst_n && w_v) begin
            resp_error = (err_beat == beat_idx);
            beat_idx++;
            seen = 1'b0;
        end else if (rst_n && r_v) begin
            rv_hi++;
            if (!noresp) begin
                if (err_beat == beat_idx) begin
                    resp_error = 1'b1;
                end else begin
                    resp_valid = 1'b1;
                    resp = (beat_idx < 2) ? rdat[beat_idx] : 32'h0;
                end
                beat_idx++;
                seen = 1'b0;
            end
        end
    end

    // Completion monitor.
    always @(negedge clk) begin
        if (rst_n && done_valid) begin
            check("done_present", 32'(done_q.size() != 0), 32'h1);
            if (done_q.size() != 0) begin
                dexp = done_q.pop_front();
                check("done_rdata", done_rdata, dexp.rdata);
                check("done_cause", {30'h0, done_cause}, {30'h0, dexp.cause});
                check("done_error", {31'h0, done_error}, {31'h0, dexp.cause != 2'd0});
                check("done_lat", 32'(cyc - acc_cyc + 1), 32'(dexp.lat));
                $display("txn %s rdata=%h err=%0b cause=%0d lat=%0d",
                         cur_tag, done_rdata, done_error, done_cause, cyc - acc_cyc + 1);
            end
        end
    end

    task automatic push_beat(input logic [31:0] a, input logic [3:0] s,
                             input logic [31:0] d, input bit chk);
        beat_t b;
        b.adr = a; b.strobe = s; b.data = d; b.chk_data = chk;
        beat_q.push_back(b);
    endtask

    task automatic start_req(input string tag, input logic we, input logic [1:0] sz,
                             input logic uns, input logic [31:0] a, input logic [31:0] wd);
        int n;
        n = 0;
        @(negedge clk);
        #1;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("ready", {31'h0, req_ready}, 32'h1);
        cur_tag = tag; rv_hi = 0; beat_idx = 0; seen = 1'b0;
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_adr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    // lat counts cycles from the accepting edge: cycle 1 follows that edge.
    task automatic run(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic [1:0] exp_cause, input int exp_lat);
        done_t d;
        int n;
        start_req(tag, we, sz, uns, a, wd);
        d.rdata = exp_rd; d.cause = exp_cause; d.lat = exp_lat;
        done_q.push_back(d);
        n = 0;
        while (done_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(done_q.size()), 32'h0);
        done_q.delete();
        @(negedge clk);
        #1;
        check("beats_used", 32'(beat_q.size()), 32'h0);
        beat_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rdat[0] = 32'h0;
        rdat[1] = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_r_v", {31'h0, r_v}, 32'h0);
        check("rst_w_v", {31'h0, w_v}, 32'h0);
        check("rst_adr", adr, 32'h0);
        check("rst_data", data, 32'h0);
        check("rst_strobe", {28'h0, strobe}, 32'h0);
        check("rst_done_valid", {31'h0, done_valid}, 32'h0);
        check("rst_done_error", {31'h0, done_error}, 32'h0);
        check("rst_done_rdata", done_rdata, 32'h0);
        check("rst_done_cause", {30'h0, done_cause}, 32'h0);
        check("rst_ready_low", {31'h0, req_ready}, 32'h0);
        rst_n = 1'b1;
        #1;
        check("rst_ready_high", {31'h0, req_ready}, 32'h1);

        push_beat(32'h4E20, 4'hF, 32'hDEADBEEF, 1'b1);
        run("st_word", 1'b1, 2'd2, 1'b0, 32'h4E20, 32'hDEADBEEF, 32'h0, 2'd0, 2);

        rdat[0] = 32'h80123456;
        push_beat(32'h4E20, 4'h8, 32'h0, 1'b0);
        run("ld_byte_s", 1'b0, 2'd0, 1'b0, 32'h4E23, 32'h0, 32'hFFFFFF80, 2'd0, 2);
        push_beat(32'h4E20, 4'h8, 32'h0, 1'b0);
        run("ld_byte_u", 1'b0, 2'd0, 1'b1, 32'h4E23, 32'h0, 32'h00000080, 2'd0, 2);

        push_beat(32'h4E20, 4'h2, 32'h0000AB00, 1'b1);
        run("st_byte", 1'b1, 2'd0, 1'b0, 32'h4E21, 32'h000000AB, 32'h0, 2'd0, 2);

        push_beat(32'h4E20, 4'hC, 32'h33440000, 1'b1);
        push_beat(32'h4E24, 4'h3, 32'h00001122, 1'b1);
        run("st_split", 1'b1, 2'd2, 1'b0, 32'h4E22, 32'h11223344, 32'h0, 2'd0, 3);

        rdat[0] = 32'hAA000000;
        rdat[1] = 32'h000000BB;
        push_beat(32'h4E20, 4'h8, 32'h0, 1'b0);
        push_beat(32'h4E24, 4'h1, 32'h0, 1'b0);
        run("ld_half_split", 1'b0, 2'd1, 1'b0, 32'h4E23, 32'h0, 32'hFFFFBBAA, 2'd0, 3);

        noresp = 1'b1;
        push_beat(32'h4E20, 4'hF, 32'h0, 1'b0);
        run("ld_timeout", 1'b0, 2'd2, 1'b0, 32'h4E20, 32'h0, 32'h0, 2'd2, 16);
        check("timeout_rv_cycles", 32'(rv_hi), 32'd15);
        noresp = 1'b0;

        err_beat = 0;
        push_beat(32'h4E20, 4'hE, 32'h0, 1'b0);
        run("ld_split_err", 1'b0, 2'd2, 1'b0, 32'h4E21, 32'h0, 32'h0, 2'd1, 2);
        push_beat(32'h4E30, 4'hF, 32'h01020304, 1'b1);
        run("st_err", 1'b1, 2'd2, 1'b0, 32'h4E30, 32'h01020304, 32'h0, 2'd1, 2);
        err_beat = -1;

        run("illegal", 1'b0, 2'd3, 1'b0, 32'h4E20, 32'h0, 32'h0, 2'd3, 1);

        push_beat(32'hFFFFFFFC, 4'hC, 32'hC3D40000, 1'b1);
        push_beat(32'h00000000, 4'h3, 32'h0000A1B2, 1'b1);
        run("st_wrap", 1'b1, 2'd2, 1'b0, 32'hFFFFFFFE, 32'hA1B2C3D4, 32'h0, 2'd0, 3);

        // Reset in the middle of a read beat: the access is dropped silently.
        noresp = 1'b1;
        push_beat(32'h00000100, 4'hF, 32'h0, 1'b0);
        start_req("rst_mid", 1'b0, 2'd2, 1'b0, 32'h00000100, 32'h0);
        @(negedge clk);
        #1;
        check("rst_mid_rv_before", {31'h0, r_v}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ready_low", {31'h0, req_ready}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("rst_mid_rv_after", {31'h0, r_v}, 32'h0);
        check("rst_mid_wv_after", {31'h0, w_v}, 32'h0);
        check("rst_mid_ready", {31'h0, req_ready}, 32'h1);
        repeat (4) @(negedge clk);
        #1;
        check("rst_mid_beats", 32'(beat_q.size()), 32'h0);
        beat_q.delete();
        noresp = 1'b0;
        seen = 1'b0;
        beat_idx = 0;

        rdat[0] = 32'h80011234;
        push_beat(32'h4E20, 4'hC, 32'h0, 1'b0);
        run("ld_half_u", 1'b0, 2'd1, 1'b1, 32'h4E22, 32'h0, 32'h00008001, 2'd0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_mem_initiator.md
# lsu_mem_initiator

Load/store initiator driving the single-word memory request interface (`r_v`/`w_v`/`adr`/`data`/`strobe` → `resp`/`resp_valid`/`resp_error`) from the core's memory stage. It accepts one byte, half or word access at a time and builds the byte strobes and lane-shifted write data. Accesses that cross a 32-bit word are split into two word beats, and read data is reassembled with sign or zero extension. A single completion pulse carries the result and any error cause back to the pipeline.

## Interface
- `XLEN`, 32: data width; only 32 is supported.
- `TIMEOUT`, 15: cycles a read beat waits for `resp_valid` before aborting.
- `clk` in 1: clock; all state updates on posedge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in 1: pipeline access request.
- `req_ready` out 1: high only in IDLE; a request is accepted on a posedge where `req_valid && req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 0 = byte, 1 = half, 2 = word; 3 is illegal.
- `req_unsigned` in 1: zero-extend load data.
- `req_adr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `done_valid` out 1: one-cycle completion pulse.
- `done_rdata` out 32: extended load data; 0 for stores and errors.
- `done_error` out 1: access failed.
- `done_cause` out 2: 0 = none, 1 = bus error, 2 = timeout, 3 = illegal size.
- `r_v`, `w_v` out 1: memory read and write request.
- `adr` out 32: word-aligned memory address.
- `data` out 32: lane-positioned write data.
- `strobe` out 4: byte enables.
- `resp` in 32: read data.
- `resp_valid` in 1: read response.
- `resp_error` in 1: responder error.

## Operation
- States: IDLE → BEAT0 → (BEAT1) → DONE → IDLE.
- Acceptance: latch all request fields. Set `off = req_adr[1:0]` and `mask8 = {4'b0, size_mask} << off`, where size_mask is 1, 3 or F.
- Split decision: the access splits when `mask8[7:4] != 0`. This covers a half at off 3 and a word at off 1, 2 or 3.
- Illegal size: `req_size == 3` goes straight to DONE with cause 3 and issues no beat.
- BEAT0:
  - `adr = {req_adr[31:2],2'b00}`
  - `strobe = mask8[3:0]`
  - `data = wdata << 8*off`
- BEAT1:
  - `adr = BEAT0 adr + 4`, wrapping mod 2^32.
  - `strobe = mask8[7:4]`
  - `data = wdata >> 8*(4-off)`
- Write beat: `w_v` is high for exactly one cycle. `resp_error` sampled in that cycle is a bus error.
- Read beat:
  - `r_v`, `adr` and `strobe` are held until `resp_valid` or `resp_error`.
  - `resp` is captured on `resp_valid`.
  - A per-beat counter aborts the beat after `TIMEOUT` cycles without a response: cause 2, `r_v` drops.
- Error on BEAT0 skips BEAT1.
- Load assembly: `{beat1,beat0} >> 8*off`, low size bytes kept, then sign- or zero-extended. For an unsplit access, beat1 reads as 0.
- DONE: `done_valid` is high for one cycle with registered results; the next state is IDLE.

## Timing
- Reset values:
  - `r_v`, `w_v` = 0; `adr`, `data`, `strobe` = 0.
  - `done_valid`, `done_error` = 0; `done_rdata` = 0; `done_cause` = 0.
  - `req_ready` = 0 while `rst_n` is low, 1 in the first cycle after release.
- All memory-side outputs are registered.
- Aligned load with a same-cycle response: accept at edge 0, `r_v` high in cycle 1, `done_valid` high in cycle 2.
- Aligned store: `done_valid` in cycle 2.
- Split access: add 1 cycle per extra write beat, plus the response wait for read beats.
- `r_v` and `w_v` are never high together, and neither is high in IDLE or DONE.
- Reset mid-operation: the next cycle is IDLE with all request lines low. No `done_valid` is issued for the abandoned access.
- `resp_valid` or `resp_error` outside a read beat is ignored, except that `resp_error` is sampled during a write beat.

## Structure
- Package `mem_if_pkg`:
  - `size_e` enum
  - `cause_e` enum
  - `lsu_state_e` enum
  - `size_mask()` function
  - `WORD_BYTES = 4`
- Sub-module `lsu_lane_align`: combinational strobe and write-data shift, plus read reassembly and extension.

## Test plan
- Aligned word store: `adr` 0x4E20, wdata 0xDEADBEEF → one `w_v` beat with `adr` 0x4E20, strobe F, data 0xDEADBEEF; `done_valid` in cycle 2, cause 0.
- Signed byte load at 0x4E23, resp 0x80123456 → rdata 0xFFFFFF80. Repeated with `req_unsigned` → 0x00000080.
- Split word store at 0x4E22, wdata 0x11223344 → beat0 at 0x4E20 with strobe C, data 0x33440000; beat1 at 0x4E24 with strobe 3, data 0x00001122.
- Split signed half load at 0x4E23, resp 0xAA000000 then 0x000000BB → rdata 0xFFFFBBAA.
- Read error paths:
  - No `resp_valid` → `r_v` drops after 15 cycles, `done_error` = 1, cause 2.
  - `resp_error` on beat0 of a split load → no beat1, cause 1.
- Reset mid-read: `rst_n` low for 1 cycle during BEAT0 → `r_v` = 0 the next cycle, no `done_valid`, `req_ready` = 1 after release. Split at `adr` 0xFFFFFFFE → beat1 `adr` 0x00000000.
